// File: rtl/pg_carry_resolver.sv
// Streaming 4-bit lookahead carry resolver over per-nibble p/g beats.
// Optional signed-overflow output enabled by defining CARRY_OVF_EN.
module pg_carry_resolver #(
    parameter int NIBBLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] p,
    input  logic [3:0] g,
    input  logic       cin,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] s,
    output logic       out_last,
    output logic       cout
`ifdef CARRY_OVF_EN
    ,
    output logic       ovf
`endif
);

    localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NIBBLES - 1);

    logic [CW-1:0] cnt;
    logic          carry_q;
    logic          accept;
    logic          last;
    logic          c0, c1, c2, c3, c4;
    logic [3:0]    sum;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign last     = (cnt == LAST_CNT);

    // First beat of an operand takes cin; later beats ripple the held carry.
    assign c0 = (cnt == '0) ? cin : carry_q;

    assign c1 = g[0] | (p[0] & c0);
    assign c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & c0);
    assign c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & c0);
    assign c4 = g[3] | (p[3] & c3);

    assign sum = p ^ {c3, c2, c1, c0};

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            carry_q <= 1'b0;
        end else if (accept) begin
            carry_q <= c4;
            cnt     <= last ? '0 : cnt + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            s         <= 4'h0;
            out_last  <= 1'b0;
            cout      <= 1'b0;
        end else if (accept) begin
            out_valid <= 1'b1;
            s         <= sum;
            out_last  <= last;
            cout      <= last ? c4 : 1'b0;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef CARRY_OVF_EN
    // Overflow is the carry into the sign bit differing from the carry out.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (accept) begin
            ovf <= last ? (c3 ^ c4) : 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_pg_carry_resolver.sv
// Scoreboard bench for pg_carry_resolver (NIBBLES=4 plus a NIBBLES=1 copy).
// Checks ovf too when CARRY_OVF_EN is defined.
module tb_pg_carry_resolver;

    localparam int N = 4;

    typedef struct packed {
        logic [3:0] s;
        logic       last;
        logic       cout;
        logic       ovf;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready;
    logic [3:0] p, g;
    logic       cin;
    logic       out_valid, out_ready;
    logic [3:0] s;
    logic       out_last, cout;
    logic       ovf;

    logic       in_valid1, in_ready1;
    logic [3:0] p1, g1;
    logic       cin1;
    logic       out_valid1;
    logic [3:0] s1;
    logic       out_last1, cout1;
    logic       ovf1;

    int n_cmp = 0;
    int n_bad = 0;
    exp_t q[$];

    always #5 clk = ~clk;

    pg_carry_resolver #(.NIBBLES(N)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .p(p), .g(g), .cin(cin),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .out_last(out_last), .cout(cout)
`ifdef CARRY_OVF_EN
        , .ovf(ovf)
`endif
    );

    pg_carry_resolver #(.NIBBLES(1)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in_valid1), .in_ready(in_ready1),
        .p(p1), .g(g1), .cin(cin1),
        .out_valid(out_valid1), .out_ready(1'b1),
        .s(s1), .out_last(out_last1), .cout(cout1)
`ifdef CARRY_OVF_EN
        , .ovf(ovf1)
`endif
    );

`ifndef CARRY_OVF_EN
    assign ovf  = 1'b0;
    assign ovf1 = 1'b0;
`endif

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard compare: one entry consumed per output transfer.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("s", 32'(s), 32'(e.s));
                chk("out_last", 32'(out_last), 32'(e.last));
                chk("cout", 32'(cout), 32'(e.cout));
`ifdef CARRY_OVF_EN
                chk("ovf", 32'(ovf), 32'(e.ovf));
`endif
            end
        end
    end

    // Drive nibble i of a+b+ci; push the expected result once accepted.
    task automatic beat(input logic [15:0] a, input logic [15:0] b,
                        input logic ci, input int i);
        logic [16:0] sum;
        exp_t e;
        int   w;
        sum = {1'b0, a} + {1'b0, b} + 17'(ci);
        e.s    = sum[4*i +: 4];
        e.last = (i == N - 1);
        e.cout = e.last ? sum[16] : 1'b0;
        e.ovf  = e.last ? ((a[15] == b[15]) && (sum[15] != a[15])) : 1'b0;
        in_valid = 1'b1;
        p   = a[4*i +: 4] ^ b[4*i +: 4];
        g   = a[4*i +: 4] & b[4*i +: 4];
        cin = (i == 0) ? ci : ~ci;
        w = 0;
        @(negedge clk);
        while (!in_ready && w < 100) begin
            w++;
            @(negedge clk);
        end
        if (!in_ready) chk("accept_timeout", 32'd1, 32'd0);
        else q.push_back(e);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic op(input logic [15:0] a, input logic [15:0] b,
                      input logic ci);
        for (int i = 0; i < N; i++) beat(a, b, ci, i);
    endtask

    initial begin
        int w;
        rst = 1'b1;
        in_valid = 1'b0; p = '0; g = '0; cin = 1'b0;
        out_ready = 1'b1;
        in_valid1 = 1'b0; p1 = '0; g1 = '0; cin1 = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_s", 32'(s), 32'd0);
        chk("rst_out_last", 32'(out_last), 32'd0);
        chk("rst_cout", 32'(cout), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
`ifdef CARRY_OVF_EN
        chk("rst_ovf", 32'(ovf), 32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;

        op(16'h1234, 16'h0FFF, 1'b0);
        op(16'hFFFF, 16'h0001, 1'b0);
        op(16'hFFFF, 16'h0000, 1'b1);

        // Backpressure after beat 1: output must hold while stalled.
        beat(16'h1234, 16'h0FFF, 1'b0, 0);
        out_ready = 1'b0;
        in_valid = 1'b1;
        p = 4'hC; g = 4'h3;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("stall_in_ready", 32'(in_ready), 32'd0);
            chk("stall_s", 32'(s), 32'd3);
            chk("stall_valid", 32'(out_valid), 32'd1);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 1; i < N; i++) beat(16'h1234, 16'h0FFF, 1'b0, i);

        // Reset in the middle of an operand.
        beat(16'hABCD, 16'h5555, 1'b1, 0);
        beat(16'hABCD, 16'h5555, 1'b1, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
        @(negedge clk);
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        op(16'h0001, 16'h0001, 1'b0);

        op(16'h7FFF, 16'h0001, 1'b0);
        op(16'h8000, 16'h8000, 1'b0);
        for (int k = 0; k < 3; k++) begin
            logic [15:0] ra, rb;
            ra = 16'($urandom);
            rb = 16'($urandom);
            op(ra, rb, 1'($urandom_range(0, 1)));
        end

        // NIBBLES=1: 0x9 + 0x8 + 1 = 0x12 on every beat.
        in_valid1 = 1'b1;
        p1 = 4'h9 ^ 4'h8;
        g1 = 4'h9 & 4'h8;
        cin1 = 1'b1;
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("n1_valid", 32'(out_valid1), 32'd1);
            chk("n1_s", 32'(s1), 32'd2);
            chk("n1_last", 32'(out_last1), 32'd1);
            chk("n1_cout", 32'(cout1), 32'd1);
`ifdef CARRY_OVF_EN
            chk("n1_ovf", 32'(ovf1), 32'd1);
`endif
            @(posedge clk);
        end
        #1;
        in_valid1 = 1'b0;

        w = 0;
        while (q.size() != 0 && w < 50) begin
            w++;
            @(posedge clk);
        end
        @(negedge clk);
        chk("drain", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
